udiv20x10: RTL and testbench



---
 rtl/udiv20x10.sv | 107 ++++++++++
 tb/tb_udiv20x10.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/udiv20x10.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor, one step per clock.
// Optional overflow / divide-by-zero detection is enabled by defining UDIV_OVF_CHECK_EN.
module udiv20x10 #(
   parameter int W = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           St,
   input  logic [2*W-1:0] Dvdnd,
   input  logic [W-1:0]   Dvsr,
   output logic [W-1:0]   Quot,
   output logic [W-1:0]   Rem,
   output logic           ovf,
   output logic           busy,
   output logic           done,
   output logic [1:0]     pstate
);

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] CHECK = 2'b01;
   localparam logic [1:0] ITER  = 2'b10;
   localparam logic [1:0] DONE  = 2'b11;

   localparam int CW = $clog2(W + 1);

   logic [1:0]    state;
   logic [2*W:0]  acc;
   logic [W-1:0]  dvsr_q;
   logic [CW-1:0] cnt;
   logic [W-1:0]  quot_q;
   logic [W-1:0]  rem_q;
   logic          ovf_q;

   logic [2*W:0]  acc_sh;
   logic [2*W:0]  acc_nx;
   logic          ovf_hit;

   // One restoring step: shift, then trial-subtract on the W+1-bit partial remainder.
   always_comb begin
      acc_sh = {acc[2*W-1:0], 1'b0};
      acc_nx = acc_sh;
      if (acc_sh[2*W:W] >= {1'b0, dvsr_q})
         acc_nx = {acc_sh[2*W:W] - {1'b0, dvsr_q}, acc_sh[W-1:1], 1'b1};
   end

`ifdef UDIV_OVF_CHECK_EN
   // A quotient that cannot fit in W bits shows up as upper dividend half >= divisor.
   assign ovf_hit = (acc[2*W-1:W] >= dvsr_q);
`else
   assign ovf_hit = 1'b0;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         acc    <= '0;
         dvsr_q <= '0;
         cnt    <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (St) begin
                  acc    <= {1'b0, Dvdnd};
                  dvsr_q <= Dvsr;
                  cnt    <= '0;
                  state  <= CHECK;
               end
            end
            CHECK: begin
               if (ovf_hit) begin
                  ovf_q <= 1'b1;
                  state <= DONE;
               end else begin
                  state <= ITER;
               end
            end
            ITER: begin
               acc <= acc_nx;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(W - 1)) begin
                  quot_q <= acc_nx[W-1:0];
                  rem_q  <= acc_nx[2*W-1:W];
                  ovf_q  <= 1'b0;
                  state  <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign Quot   = quot_q;
   assign Rem    = rem_q;
`ifdef UDIV_OVF_CHECK_EN
   assign ovf    = ovf_q;
`else
   assign ovf    = 1'b0;
`endif
   assign busy   = (state != IDLE);
   assign done   = (state == DONE);
   assign pstate = state;

endmodule

// File: tb/tb_udiv20x10.sv
// Directed self-checking bench for udiv20x10 (W=10); follows UDIV_OVF_CHECK_EN when defined.
module tb_udiv20x10;

   localparam int W = 10;

   logic           clk;
   logic           rst_n;
   logic           St;
   logic [2*W-1:0] Dvdnd;
   logic [W-1:0]   Dvsr;
   logic [W-1:0]   Quot;
   logic [W-1:0]   Rem;
   logic           ovf;
   logic           busy;
   logic           done;
   logic [1:0]     pstate;

   int n_checks;
   int n_fail;

   udiv20x10 #(.W(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .St     (St),
      .Dvdnd  (Dvdnd),
      .Dvsr   (Dvsr),
      .Quot   (Quot),
      .Rem    (Rem),
      .ovf    (ovf),
      .busy   (busy),
      .done   (done),
      .pstate (pstate)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present operands with St for one edge (the accepting edge E0), then drop St.
   task automatic pulse_start(input logic [2*W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      St    = 1'b1;
      Dvdnd = a;
      Dvsr  = b;
      @(posedge clk);
      #1;
      St = 1'b0;
   endtask

   // Edges after E0 until done is seen high; -1 if the budget expires.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      St    = 1'b0;
      Dvdnd = '0;
      Dvsr  = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({Quot, Rem, ovf, busy, done, pstate} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got Quot=%0d Rem=%0d ovf=%b busy=%b done=%b pstate=%b, want all 0",
                  Quot, Rem, ovf, busy, done, pstate);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_divide(input string name, input logic [2*W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] eq, input logic [W-1:0] er);
      int lat;
      pulse_start(a, b);
      n_checks++;
      if (pstate !== 2'b01 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_check_state: got pstate=%b busy=%b, want 01/1", name, pstate, busy);
      end
      wait_done(lat);
      n_checks++;
      if (lat !== W + 1) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d edges after accept, want %0d", name, lat, W + 1);
      end
      n_checks++;
      if (Quot !== eq || Rem !== er || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_result: got Q=%0d R=%0d ovf=%b, want Q=%0d R=%0d ovf=0",
                  name, Quot, Rem, ovf, eq, er);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0 || pstate !== 2'b00 || Quot !== eq || Rem !== er) begin
         n_fail++;
         $display("FAIL %s_after_done: got done=%b pstate=%b Q=%0d R=%0d, want 0/00/%0d/%0d",
                  name, done, pstate, Quot, Rem, eq, er);
      end
   endtask

   task automatic test_overflow;
`ifdef UDIV_OVF_CHECK_EN
      int lat;
      // Previous result is 142 r 6 and must survive the overflow completions.
      pulse_start(20'd5120, 10'd5);
      wait_done(lat);
      n_checks++;
      if (lat !== 1) begin
         n_fail++;
         $display("FAIL ovf_latency: got %0d, want 1", lat);
      end
      n_checks++;
      if (ovf !== 1'b1 || Quot !== 10'd142 || Rem !== 10'd6) begin
         n_fail++;
         $display("FAIL ovf_result: got ovf=%b Q=%0d R=%0d, want 1/142/6", ovf, Quot, Rem);
      end
      @(posedge clk);
      pulse_start(20'd123, 10'd0);
      wait_done(lat);
      n_checks++;
      if (lat !== 1 || ovf !== 1'b1 || Quot !== 10'd142 || Rem !== 10'd6) begin
         n_fail++;
         $display("FAIL div0_ovf: got lat=%0d ovf=%b Q=%0d R=%0d, want 1/1/142/6", lat, ovf, Quot, Rem);
      end
      @(posedge clk);
`else
      int lat;
      pulse_start(20'd123, 10'd0);
      wait_done(lat);
      n_checks++;
      if (lat !== W + 1 || Quot !== 10'd1023 || Rem !== 10'd123 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL div0_raw: got lat=%0d Q=%0d R=%0d ovf=%b, want 11/1023/123/0", lat, Quot, Rem, ovf);
      end
      @(posedge clk);
`endif
   endtask

   task automatic test_back_to_back;
      int pulses;
      pulse_start(20'd1000, 10'd7);
      repeat (4) @(posedge clk);
      @(negedge clk);
      St    = 1'b1;
      Dvdnd = 20'd5000;
      Dvsr  = 10'd3;
      @(negedge clk);
      St = 1'b0;
      pulses = 0;
      for (int n = 0; n < 25; n++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      n_checks++;
      if (pulses !== 1) begin
         n_fail++;
         $display("FAIL busy_start_pulses: got %0d done pulses, want 1", pulses);
      end
      n_checks++;
      if (Quot !== 10'd142 || Rem !== 10'd6 || pstate !== 2'b00) begin
         n_fail++;
         $display("FAIL busy_start_result: got Q=%0d R=%0d pstate=%b, want 142/6/00", Quot, Rem, pstate);
      end
   endtask

   task automatic test_reset_mid;
      int pulses;
      pulse_start(20'd1047551, 10'd1023);
      repeat (6) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({Quot, Rem, ovf, busy, done, pstate} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got Q=%0d R=%0d ovf=%b busy=%b done=%b pstate=%b, want all 0",
                  Quot, Rem, ovf, busy, done, pstate);
      end
      pulses = 0;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 15; n++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      n_checks++;
      if (pulses !== 0 || pstate !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_mid_no_done: got %0d pulses pstate=%b, want 0/00", pulses, pstate);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_divide("basic", 20'd1000, 10'd7, 10'd142, 10'd6);
      test_overflow();
      test_divide("max", 20'd1047551, 10'd1023, 10'd1023, 10'd1022);
      test_divide("q1001", 20'd1000000, 10'd999, 10'd1001 - 10'd0, 10'd1);
      test_divide("basic2", 20'd1000, 10'd7, 10'd142, 10'd6);
      test_back_to_back();
      test_reset_mid();
      test_divide("after_reset", 20'd54321, 10'd100, 10'd543, 10'd21);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
